// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate tick, horizontal/vertical position
// counters, sync pulses, active-video flag and a start-of-frame pulse.
module vga_sync_gen #(
  parameter int   CLK_DIV  = 4,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pixel_tick,
  output logic [15:0] h_counter,
  output logic [15:0] v_counter,
  output logic        hsync,
  output logic        vsync,
  output logic        video_out,
  output logic        frame_start
);

  localparam logic [3:0]  DIV_LAST  = 4'(CLK_DIV - 1);
  localparam logic [15:0] H_LAST    = 16'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [15:0] V_LAST    = 16'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [15:0] H_SYNC_END = 16'(H_SYNC);
  localparam logic [15:0] V_SYNC_END = 16'(V_SYNC);
  localparam logic [15:0] H_VIS_LO  = 16'(H_SYNC + H_BP);
  localparam logic [15:0] H_VIS_HI  = 16'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [15:0] V_VIS_LO  = 16'(V_SYNC + V_BP);
  localparam logic [15:0] V_VIS_HI  = 16'(V_SYNC + V_BP + V_ACTIVE - 1);

  logic [3:0]  div_cnt;
  logic [15:0] h_next;
  logic [15:0] v_next;
  logic        frame_wrap;
  logic        h_vis_next;
  logic        v_vis_next;

  // Pixel tick decoded straight from the divider register (no added latency).
  always_comb begin
    pixel_tick = (div_cnt == DIV_LAST);
  end

  // Next raster position; sync/video flags are derived from it so that the
  // registered flags line up with the registered counters in the same cycle.
  always_comb begin
    h_next     = h_counter;
    v_next     = v_counter;
    frame_wrap = 1'b0;
    if (pixel_tick) begin
      if (h_counter == H_LAST) begin
        h_next = '0;
        if (v_counter == V_LAST) begin
          v_next     = '0;
          frame_wrap = 1'b1;
        end else begin
          v_next = v_counter + 16'd1;
        end
      end else begin
        h_next = h_counter + 16'd1;
      end
    end
    h_vis_next = (h_next >= H_VIS_LO) && (h_next <= H_VIS_HI);
    v_vis_next = (v_next >= V_VIS_LO) && (v_next <= V_VIS_HI);
  end

  // Clock divider: counts 0..CLK_DIV-1 and wraps on the tick cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (pixel_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

  // Position counters plus registered sync, video and frame-start outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_counter   <= '0;
      v_counter   <= '0;
      hsync       <= SYNC_POL;
      vsync       <= SYNC_POL;
      video_out   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_counter   <= h_next;
      v_counter   <= v_next;
      hsync       <= (h_next < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (v_next < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      video_out   <= h_vis_next && v_vis_next;
      frame_start <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default timing, a small fast
// raster with active-high sync, and an undivided pixel clock), each checked
// every cycle against a position model computed from elapsed clocks.
module tb_vga_sync_gen;

  typedef struct packed {
    logic        tick;
    logic [15:0] h;
    logic [15:0] v;
    logic        hs;
    logic        vs;
    logic        vid;
    logic        fs;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  logic        a_tick, a_hs, a_vs, a_vid, a_fs;
  logic [15:0] a_h, a_v;
  logic        b_tick, b_hs, b_vs, b_vid, b_fs;
  logic [15:0] b_h, b_v;
  logic        c_tick, c_hs, c_vs, c_vid, c_fs;
  logic [15:0] c_h, c_v;

  int errors = 0;
  int checks = 0;

  vga_sync_gen dut_a (
    .clk(clk), .reset(rst_a), .pixel_tick(a_tick), .h_counter(a_h),
    .v_counter(a_v), .hsync(a_hs), .vsync(a_vs), .video_out(a_vid),
    .frame_start(a_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(3), .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_ACTIVE(5), .V_FP(2), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .reset(rst_b), .pixel_tick(b_tick), .h_counter(b_h),
    .v_counter(b_v), .hsync(b_hs), .vsync(b_vs), .video_out(b_vid),
    .frame_start(b_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(1)
  ) dut_c (
    .clk(clk), .reset(rst_c), .pixel_tick(c_tick), .h_counter(c_h),
    .v_counter(c_v), .hsync(c_hs), .vsync(c_vs), .video_out(c_vid),
    .frame_start(c_fs)
  );

  // Raster position as a pure function of clocks elapsed since reset.
  function automatic exp_t model(input int unsigned c, input int unsigned d,
                                 input int unsigned hs, input int unsigned hb,
                                 input int unsigned ha, input int unsigned hf,
                                 input int unsigned vs, input int unsigned vb,
                                 input int unsigned va, input int unsigned vf,
                                 input logic pol);
    exp_t e;
    int unsigned ht = hs + hb + ha + hf;
    int unsigned vt = vs + vb + va + vf;
    int unsigned p  = c / d;
    int unsigned h  = p % ht;
    int unsigned v  = (p / ht) % vt;
    e.tick = ((c % d) == d - 1);
    e.h    = 16'(h);
    e.v    = 16'(v);
    e.hs   = (h < hs) ? pol : ~pol;
    e.vs   = (v < vs) ? pol : ~pol;
    e.vid  = (h >= hs + hb) && (h < hs + hb + ha) && (v >= vs + vb) && (v < vs + vb + va);
    e.fs   = ((c % d) == 0) && (p != 0) && ((p % (ht * vt)) == 0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_inst(input string pfx, input int unsigned c, input int unsigned d,
                            input int unsigned hs, input int unsigned hb,
                            input int unsigned ha, input int unsigned hf,
                            input int unsigned vs, input int unsigned vb,
                            input int unsigned va, input int unsigned vf,
                            input logic pol, input logic tick,
                            input logic [15:0] h, input logic [15:0] v,
                            input logic hsn, input logic vsn, input logic vid,
                            input logic fs);
    exp_t e = model(c, d, hs, hb, ha, hf, vs, vb, va, vf, pol);
    check({pfx, "_tick"}, 16'(tick), 16'(e.tick));
    check({pfx, "_h"}, h, e.h);
    check({pfx, "_v"}, v, e.v);
    check({pfx, "_hsync"}, 16'(hsn), 16'(e.hs));
    check({pfx, "_vsync"}, 16'(vsn), 16'(e.vs));
    check({pfx, "_video"}, 16'(vid), 16'(e.vid));
    check({pfx, "_frame_start"}, 16'(fs), 16'(e.fs));
  endtask

  // Clocks elapsed since each instance's last reset edge.
  int unsigned ca = 0, cb = 0, cc = 0;
  logic arm_a = 1'b0, arm_b = 1'b0, arm_c = 1'b0;

  always @(posedge clk) begin
    if (rst_a) begin ca <= 0; arm_a <= 1'b1; end else ca <= ca + 1;
    if (rst_b) begin cb <= 0; arm_b <= 1'b1; end else cb <= cb + 1;
    if (rst_c) begin cc <= 0; arm_c <= 1'b1; end else cc <= cc + 1;
  end

  // Per-cycle model comparison plus fixed-point boundary checks.
  always @(negedge clk) begin
    if (arm_a) begin
      check_inst("a", ca, 4, 96, 48, 640, 16, 2, 33, 480, 10, 1'b0,
                 a_tick, a_h, a_v, a_hs, a_vs, a_vid, a_fs);
      if (ca == 2)        check("a_no_tick_c2", 16'(a_tick), 16'd0);
      if (ca == 3)        check("a_first_tick", 16'(a_tick), 16'd1);
      if (ca == 4)        check("a_h_at_c4", a_h, 16'd1);
      if (ca == 95 * 4)   check("a_hsync_h95", 16'(a_hs), 16'd0);
      if (ca == 96 * 4)   check("a_hsync_h96", 16'(a_hs), 16'd1);
      if (ca == 3199)     check("a_h_end_line", a_h, 16'd799);
      if (ca == 3200)     check("a_line_len_h", a_h, 16'd0);
      if (ca == 3200)     check("a_line_len_v", a_v, 16'd1);
    end
    if (arm_b) begin
      check_inst("b", cb, 3, 4, 3, 8, 2, 2, 2, 5, 2, 1'b1,
                 b_tick, b_h, b_v, b_hs, b_vs, b_vid, b_fs);
      if (cb == 3 * 3)              check("b_hsync_h3", 16'(b_hs), 16'd1);
      if (cb == 3 * 4)              check("b_hsync_h4", 16'(b_hs), 16'd0);
      if (cb == 3 * (4 * 17 + 6))   check("b_video_h6v4", 16'(b_vid), 16'd0);
      if (cb == 3 * (4 * 17 + 7))   check("b_video_h7v4", 16'(b_vid), 16'd1);
      if (cb == 3 * (8 * 17 + 14))  check("b_video_h14v8", 16'(b_vid), 16'd1);
      if (cb == 3 * (8 * 17 + 15))  check("b_video_h15v8", 16'(b_vid), 16'd0);
      if (cb == 3 * (9 * 17 + 10))  check("b_video_v9", 16'(b_vid), 16'd0);
      if (cb == 561)                check("b_frame_start", 16'(b_fs), 16'd1);
      if (cb == 562)                check("b_frame_start_end", 16'(b_fs), 16'd0);
      if (cb == 1122)               check("b_frame_start_2", 16'(b_fs), 16'd1);
    end
    if (arm_c) begin
      check_inst("c", cc, 1, 96, 48, 640, 16, 2, 33, 480, 10, 1'b0,
                 c_tick, c_h, c_v, c_hs, c_vs, c_vid, c_fs);
      if (cc == 0)   check("c_tick_c0", 16'(c_tick), 16'd1);
      if (cc == 1)   check("c_h_c1", c_h, 16'd1);
      if (cc == 799) check("c_h_799", c_h, 16'd799);
      if (cc == 800) check("c_line_len", c_v, 16'd1);
    end
  end

  int unsigned hold_b;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    repeat (5) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    // Default instance: past the end of the first line, then a one-clock
    // mid-line reset and a replay of the start-up timing.
    repeat (3300) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    // Small instance: random reset pulses at arbitrary raster positions.
    hold_b = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (rst_b) begin
        if (hold_b == 0) rst_b = 1'b0;
        else hold_b--;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_b  = 1'b1;
        hold_b = $urandom_range(0, 2);
      end
    end
    rst_b = 1'b0;
    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
